// File: rtl/rr_vc_grant_arbiter_pkg.sv
// rtl/rr_vc_grant_arbiter_pkg.sv - shared state codes and width helper for the VC arbiter slice
package rr_vc_grant_arbiter_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Index width for n entries; a single entry still gets a 1-bit index.
  function automatic int Log2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 5; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_vc_pick.sv
// rtl/rr_vc_pick.sv - combinational rotate-priority picker: first asserted req at or after the start index
module rr_vc_pick
  import rr_vc_grant_arbiter_pkg::*;
#(
  parameter int NUM_VC = 4,
  localparam int TOKEN_W = Log2(NUM_VC)
) (
  input  logic [NUM_VC-1:0]  req_i,
  input  logic [TOKEN_W-1:0] start_i,
  output logic [NUM_VC-1:0]  onehot_o,
  output logic [TOKEN_W-1:0] idx_o,
  output logic               found_o
);

  generate
    if (NUM_VC == 1) begin : g_single
      assign onehot_o = req_i;
      assign idx_o    = '0;
      assign found_o  = req_i[0];
    end else begin : g_multi
      localparam logic [TOKEN_W:0] NV = NUM_VC[TOKEN_W:0];
      logic [TOKEN_W:0] s;
      logic [TOKEN_W:0] c;

      always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        c        = '0;
        // An out-of-range token restarts the search at VC0.
        s = ({1'b0, start_i} >= NV) ? '0 : {1'b0, start_i};
        for (int i = 0; i < NUM_VC; i++) begin
          c = s + (TOKEN_W+1)'(i);
          if (c >= NV) c = c - NV;
          if (!found_o && req_i[c[TOKEN_W-1:0]]) begin
            found_o                   = 1'b1;
            idx_o                     = c[TOKEN_W-1:0];
            onehot_o[c[TOKEN_W-1:0]]  = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rr_vc_grant_arbiter.sv
// rtl/rr_vc_grant_arbiter.sv - round-robin VC arbiter with packet grant lock; RR_VC_ARB_GRANT_CNT_EN adds grant_cnt/abort_seen
module rr_vc_grant_arbiter
  import rr_vc_grant_arbiter_pkg::*;
#(
  parameter int NUM_VC = 4,
  localparam int TOKEN_W = Log2(NUM_VC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_VC-1:0]  req,
  input  logic [TOKEN_W-1:0] token,
  input  logic               xfer,
  input  logic               tail,
`ifdef RR_VC_ARB_GRANT_CNT_EN
  output logic [15:0]        grant_cnt,
  output logic               abort_seen,
`endif
  output logic [NUM_VC-1:0]  grant,
  output logic               grant_valid,
  output logic [TOKEN_W-1:0] grant_id,
  output logic [NUM_VC-1:0]  grant_new
);

  logic               state_q, state_d;
  logic [NUM_VC-1:0]  grant_q, grant_d;
  logic [TOKEN_W-1:0] grant_id_q, grant_id_d;
  logic [NUM_VC-1:0]  grant_new_q, grant_new_d;

  logic [NUM_VC-1:0]  pick_onehot;
  logic [TOKEN_W-1:0] pick_idx;
  logic               pick_found;
  logic               withdrawn;
  logic               release_now;

  rr_vc_pick #(.NUM_VC(NUM_VC)) u_pick (
    .req_i    (req),
    .start_i  (token),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign withdrawn = ~|(req & grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      grant_new_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      grant_new_q <= grant_new_d;
    end
  end

  // IDLE is treated as a permanently released grant so both states share the pick path.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    grant_new_d = '0;
    if (state_q == ST_IDLE) release_now = 1'b1;
    else                    release_now = (xfer && tail) || withdrawn;
    if (release_now) begin
      if (pick_found) begin
        state_d     = ST_BUSY;
        grant_d     = pick_onehot;
        grant_id_d  = pick_idx;
        grant_new_d = pick_onehot;
      end else begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    end
  end

  always_comb begin
    grant       = grant_q;
    grant_valid = |grant_q;
    grant_id    = grant_id_q;
    grant_new   = grant_new_q;
  end

`ifdef RR_VC_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q;
  logic        abort_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q  <= '0;
      abort_seen_q <= 1'b0;
    end else begin
      if (|grant_new_q) grant_cnt_q <= grant_cnt_q + 16'd1;
      if (state_q == ST_BUSY && withdrawn && !(xfer && tail)) abort_seen_q <= 1'b1;
    end
  end

  assign grant_cnt  = grant_cnt_q;
  assign abort_seen = abort_seen_q;
`endif

endmodule

// File: tb/tb_rr_vc_grant_arbiter.sv
// tb/tb_rr_vc_grant_arbiter.sv - directed self-checking bench for rr_vc_grant_arbiter (NUM_VC=4 and NUM_VC=5)
module tb_rr_vc_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] token;
  logic       xfer;
  logic       tail;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] grant_new;

  logic [4:0] req5;
  logic [2:0] token5;
  logic [4:0] grant5;
  logic       grant_valid5;
  logic [2:0] grant_id5;
  logic [4:0] grant_new5;

`ifdef RR_VC_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt, grant_cnt5;
  logic        abort_seen, abort_seen5;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_vc_grant_arbiter #(.NUM_VC(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .token       (token),
    .xfer        (xfer),
    .tail        (tail),
`ifdef RR_VC_ARB_GRANT_CNT_EN
    .grant_cnt   (grant_cnt),
    .abort_seen  (abort_seen),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_new   (grant_new)
  );

  rr_vc_grant_arbiter #(.NUM_VC(5)) u_dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req5),
    .token       (token5),
    .xfer        (xfer),
    .tail        (tail),
`ifdef RR_VC_ARB_GRANT_CNT_EN
    .grant_cnt   (grant_cnt5),
    .abort_seen  (abort_seen5),
`endif
    .grant       (grant5),
    .grant_valid (grant_valid5),
    .grant_id    (grant_id5),
    .grant_new   (grant_new5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; token = '0; xfer = 1'b0; tail = 1'b0;
    req5 = '0; token5 = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", grant_id); end
    total++; if (grant_new !== 4'b0000) begin bad++; $display("FAIL reset_new got=%b exp=0000", grant_new); end
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_noreq_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_basic();
    do_reset();
    token = 2'd0; req = 4'b0110;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL basic_grant got=%b exp=0010", grant); end
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL basic_id got=%0d exp=1", grant_id); end
    total++; if (grant_new !== 4'b0010) begin bad++; $display("FAIL basic_new got=%b exp=0010", grant_new); end
    total++; if (grant_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", grant_valid); end
    tick();
    total++; if (grant_new !== 4'b0000) begin bad++; $display("FAIL basic_new_drop got=%b exp=0000", grant_new); end
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL basic_hold got=%b exp=0010", grant); end
  endtask

  task automatic test_wrap();
    do_reset();
    token = 2'd3; req = 4'b0011;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%b exp=0001", grant); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL wrap_id got=%0d exp=0", grant_id); end
  endtask

  task automatic test_token_range();
    do_reset();
    token5 = 3'd6; req5 = 5'b00010;
    tick();
    total++; if (grant5 !== 5'b00010) begin bad++; $display("FAIL oor_grant got=%b exp=00010", grant5); end
    total++; if (grant_id5 !== 3'd1) begin bad++; $display("FAIL oor_id got=%0d exp=1", grant_id5); end
    req5 = 5'b00000;
    tick();
    total++; if (grant5 !== 5'b00000) begin bad++; $display("FAIL n5_release got=%b exp=00000", grant5); end
    token5 = 3'd3; req5 = 5'b10011;
    tick();
    total++; if (grant5 !== 5'b10000) begin bad++; $display("FAIL n5_wrap_grant got=%b exp=10000", grant5); end
    total++; if (grant_id5 !== 3'd4) begin bad++; $display("FAIL n5_wrap_id got=%0d exp=4", grant_id5); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    token = 2'd2; req = 4'b1101;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL b2b_first got=%b exp=0100", grant); end
    xfer = 1'b1; tail = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL b2b_lock%0d got=%b exp=0100", i, grant); end
      total++; if (grant_new !== 4'b0000) begin bad++; $display("FAIL b2b_lock_new%0d got=%b exp=0000", i, grant_new); end
    end
    tail = 1'b1; token = 2'd3;
    tick();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL b2b_next got=%b exp=1000", grant); end
    total++; if (grant_new !== 4'b1000) begin bad++; $display("FAIL b2b_next_new got=%b exp=1000", grant_new); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL b2b_next_id got=%0d exp=3", grant_id); end
    xfer = 1'b0; tail = 1'b1;
    tick();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL tail_noxfer got=%b exp=1000", grant); end
    total++; if (grant_new !== 4'b0000) begin bad++; $display("FAIL tail_noxfer_new got=%b exp=0000", grant_new); end
    xfer = 1'b1; token = 2'd0;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL b2b_token0 got=%b exp=0001", grant); end
    total++; if (grant_new !== 4'b0001) begin bad++; $display("FAIL b2b_token0_new got=%b exp=0001", grant_new); end
    xfer = 1'b0; tail = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    token = 2'd1; req = 4'b0010;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL abort_pre got=%b exp=0010", grant); end
    req = 4'b0000;
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL abort_grant got=%b exp=0000", grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", grant_valid); end
`ifdef RR_VC_ARB_GRANT_CNT_EN
    total++; if (abort_seen !== 1'b1) begin bad++; $display("FAIL abort_seen got=%b exp=1", abort_seen); end
    total++; if (grant_cnt !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d exp=1", grant_cnt); end
`endif
    xfer = 1'b1; tail = 1'b1;
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_xfer got=%b exp=0000", grant); end
    total++; if (grant_new !== 4'b0000) begin bad++; $display("FAIL idle_xfer_new got=%b exp=0000", grant_new); end
    xfer = 1'b0; tail = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    token = 2'd2; req = 4'b0100;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL areset_pre got=%b exp=0100", grant); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL areset_grant got=%b exp=0000", grant); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", grant_valid); end
    req = 4'b1111; token = 2'd2;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL areset_after got=%b exp=0100", grant); end
    total++; if (grant_new !== 4'b0100) begin bad++; $display("FAIL areset_after_new got=%b exp=0100", grant_new); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_token_range();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
